// File: rtl/zip_memsched_pkg.sv
// Shared types and constants for the ZipCPU load/store issue scheduler.
package zip_memsched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        TERMINAL,
        FLUSH
    } state_e;

    localparam int         OP_WR_BIT   = 0;
    localparam logic [2:0] SPECIAL_REG = 3'h7;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [4:0]  oreg;
        logic [4:0]  areg;
        logic        lock;
    } mreq_t;

    // A read that loads PC/CC, or overwrites its own base register, must end its string.
    function automatic logic is_terminal_read(input mreq_t r);
        return !r.op[OP_WR_BIT] && ((r.oreg[3:1] == SPECIAL_REG) || (r.oreg == r.areg));
    endfunction

endpackage

// File: rtl/zip_memsched_slot.sv
// One-entry pending request register: ready/valid on the input, taken by the strobe, dropped on discard.
module zip_memsched_slot
    import zip_memsched_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  enable_i,
    input  logic  in_valid_i,
    output logic  in_ready_o,
    input  mreq_t in_req_i,
    input  logic  take_i,
    input  logic  discard_i,
    output logic  out_valid_o,
    output mreq_t out_req_o
);

    logic  full_q, full_d;
    mreq_t req_q, req_d;

    assign in_ready_o  = enable_i && (!full_q || take_i);
    assign out_valid_o = full_q;
    assign out_req_o   = req_q;

    always_comb begin
        full_d = full_q;
        req_d  = req_q;
        if (take_i)
            full_d = 1'b0;
        if (in_valid_i && in_ready_o) begin
            full_d = 1'b1;
            req_d  = in_req_i;
        end
        // Discard beats a same-cycle accept: nothing survives an error.
        if (discard_i)
            full_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            req_q  <= '0;
        end else begin
            full_q <= full_d;
            req_q  <= req_d;
        end
    end

endmodule

// File: rtl/zip_memsched.sv
// Issue scheduler between the ZipCPU load/store stage and the memory unit.
module zip_memsched
    import zip_memsched_pkg::*;
#(
    parameter int   OPT_MAXDEPTH   = 4,
    parameter int   LGDEPTH        = 4,
    parameter logic IMPLEMENT_LOCK = 1'b0
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_req,
    output logic               o_req_ready,
    input  logic [2:0]         i_op,
    input  logic [31:0]        i_addr,
    input  logic [31:0]        i_data,
    input  logic [4:0]         i_oreg,
    input  logic [4:0]         i_areg,
    input  logic               i_lock,
    input  logic               i_clear_cache,
    output logic               o_stb,
    output logic [2:0]         o_op,
    output logic [31:0]        o_addr,
    output logic [31:0]        o_data,
    output logic [4:0]         o_oreg,
    output logic               o_lock,
    output logic               o_clear_cache,
    input  logic               i_pipe_stalled,
    input  logic               i_busy,
    input  logic               i_rdbusy,
    input  logic               i_valid,
    input  logic               i_done,
    input  logic               i_err,
    input  logic [4:0]         i_wreg,
    output logic [LGDEPTH-1:0] o_outstanding,
    output logic               o_read_cycle,
    output logic               o_pending_err
);

    localparam logic [LGDEPTH-1:0] MAXD    = LGDEPTH'(OPT_MAXDEPTH);
    localparam logic [LGDEPTH-1:0] CNT_MAX = '1;

    state_e             state_q, state_d;
    logic [LGDEPTH-1:0] cnt_q, cnt_d;
    logic               read_cycle_q, read_cycle_d;
    logic [4:0]         base_q, base_d;
    logic               gie_q, gie_d;
    logic               lock_q, lock_d;
    logic               clr_done_q;
    logic               run_q;

    mreq_t in_req, slot_req;
    logic  slot_full, slot_wr, term, issue_ok;

    // Return data and read-busy are consumed downstream; issue decisions only need busy/done/err.
    logic unused_status;
    assign unused_status = ^{i_rdbusy, i_valid, i_wreg};

    assign in_req = '{op: i_op, addr: i_addr, data: i_data, oreg: i_oreg,
                      areg: i_areg, lock: IMPLEMENT_LOCK & i_lock};

    zip_memsched_slot u_slot (
        .clk_i       (i_clk),
        .rst_ni      (i_reset_n),
        .enable_i    (run_q),
        .in_valid_i  (i_req),
        .in_ready_o  (o_req_ready),
        .in_req_i    (in_req),
        .take_i      (o_stb),
        .discard_i   (i_err),
        .out_valid_o (slot_full),
        .out_req_o   (slot_req)
    );

    assign slot_wr = slot_req.op[OP_WR_BIT];
    assign term    = is_terminal_read(slot_req);

    always_comb begin
        issue_ok = (cnt_q < MAXD) && (state_q != TERMINAL) && !i_clear_cache;
        // While the unit is busy the new request must continue the current string.
        if (i_busy) begin
            if (slot_wr == read_cycle_q)
                issue_ok = 1'b0;
            if (slot_req.oreg[4] != gie_q)
                issue_ok = 1'b0;
            if (!slot_wr && (slot_req.areg != base_q))
                issue_ok = 1'b0;
            if (IMPLEMENT_LOCK && slot_req.lock && !lock_q)
                issue_ok = 1'b0;
        end
    end

    assign o_stb = slot_full && issue_ok && !i_pipe_stalled && !i_err && (state_q != FLUSH);

    assign o_clear_cache = run_q && i_clear_cache && !clr_done_q
                        && (cnt_q == '0) && !i_busy && !o_stb;

    assign o_op          = slot_req.op;
    assign o_addr        = slot_req.addr;
    assign o_data        = slot_req.data;
    assign o_oreg        = slot_req.oreg;
    assign o_lock        = IMPLEMENT_LOCK && (o_stb ? slot_req.lock : (lock_q && i_busy));
    assign o_outstanding = cnt_q;
    assign o_read_cycle  = read_cycle_q;
    assign o_pending_err = (state_q == FLUSH);

    always_comb begin
        cnt_d = cnt_q;
        if (i_err)
            cnt_d = '0;
        else if (o_stb && !i_done && (cnt_q != CNT_MAX))
            cnt_d = cnt_q + 1'b1;
        else if (i_done && !o_stb && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
    end

    always_comb begin
        lock_d = o_stb ? slot_req.lock : (lock_q && i_busy);
        if (i_err)
            lock_d = 1'b0;
    end

    always_comb begin
        state_d      = state_q;
        read_cycle_d = read_cycle_q;
        base_d       = base_q;
        gie_d        = gie_q;
        case (state_q)
            IDLE, RD, WR: begin
                if (o_stb) begin
                    // A strobe with the unit idle starts a new string.
                    if ((state_q == IDLE) || !i_busy) begin
                        base_d = slot_req.areg;
                        gie_d  = slot_req.oreg[4];
                    end
                    read_cycle_d = !slot_wr;
                    if (slot_wr)
                        state_d = WR;
                    else if (term)
                        state_d = TERMINAL;
                    else
                        state_d = RD;
                end else if ((state_q != IDLE) && (cnt_q == '0) && !i_busy) begin
                    state_d = IDLE;
                end
            end
            TERMINAL: if ((cnt_q == '0) && !i_busy) state_d = IDLE;
            FLUSH:    if (!i_busy) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        if (i_err)
            state_d = FLUSH;
        if (o_clear_cache || (state_d == IDLE))
            read_cycle_d = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            read_cycle_q <= 1'b0;
            base_q       <= '0;
            gie_q        <= 1'b0;
            lock_q       <= 1'b0;
            clr_done_q   <= 1'b0;
            run_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            read_cycle_q <= read_cycle_d;
            base_q       <= base_d;
            gie_q        <= gie_d;
            lock_q       <= lock_d;
            clr_done_q   <= i_clear_cache && (clr_done_q || o_clear_cache);
            run_q        <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset_n && !i_err) begin
            assert (!(o_stb && !i_done && (cnt_q == CNT_MAX)));
            assert (!(i_done && !o_stb && (cnt_q == '0)));
        end
    end

endmodule
